// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Optional macro PIPE_CTRL_FWD_EN: EX/MEM forwarding present, so only load-use/branch hazards stall.
module pipeline_hazard_ctrl #(
   parameter int unsigned REG_AW    = 4,
   parameter int unsigned DRAIN_CYC = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs_fd,
   input  logic [REG_AW-1:0] rt_fd,
   input  logic              use_rs_fd,
   input  logic              use_rt_fd,
   input  logic              br_fd,
   input  logic              br_reg_fd,
   input  logic              br_taken,
   input  logic              hlt_fd,
   input  logic              wr_dx,
   input  logic [REG_AW-1:0] dst_dx,
   input  logic              mrd_dx,
   input  logic              flag_wr_dx,
   input  logic              wr_xm,
   input  logic [REG_AW-1:0] dst_xm,
   input  logic              mrd_xm,
   input  logic              mem_busy,
   output logic              pc_we,
   output logic              fd_we,
   output logic              fd_flush,
   output logic              dx_we,
   output logic              dx_flush,
   output logic              xm_we,
   output logic              mw_we,
   output logic              halted,
   output logic [15:0]       stall_cnt
);

   localparam int unsigned CTR_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [CTR_W-1:0] DRAIN_LOAD = CTR_W'(DRAIN_CYC - 1);
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DRAIN  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CTR_W-1:0] drain_ctr, drain_ctr_nxt;
   logic [15:0]      stall_cnt_nxt;

   logic rs_live, rt_live, dx_live, xm_live;
   logic raw_dx, raw_xm;
   logic lu_haz, brr_haz, flag_haz, haz;

   // R0 is hardwired zero, so it never sources or sinks a hazard
   assign rs_live = use_rs_fd & (rs_fd != '0);
   assign rt_live = use_rt_fd & (rt_fd != '0);
   assign dx_live = wr_dx & (dst_dx != '0);
   assign xm_live = wr_xm & (dst_xm != '0);

   assign raw_dx = dx_live & ((rs_live & (rs_fd == dst_dx)) | (rt_live & (rt_fd == dst_dx)));
   assign raw_xm = xm_live & ((rs_live & (rs_fd == dst_xm)) | (rt_live & (rt_fd == dst_xm)));

   assign lu_haz   = raw_dx & mrd_dx;
   assign brr_haz  = br_reg_fd & (raw_dx | (raw_xm & mrd_xm));
   assign flag_haz = br_fd & flag_wr_dx;

`ifdef PIPE_CTRL_FWD_EN
   assign haz = lu_haz | brr_haz | flag_haz;
`else
   assign haz = lu_haz | brr_haz | flag_haz | raw_dx | raw_xm;
`endif

   // State, drain counter and stall counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RUN;
         drain_ctr <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_ctr <= drain_ctr_nxt;
         stall_cnt <= stall_cnt_nxt;
      end
   end

   // Next-state and enable/flush decode, in priority order
   always_comb begin
      state_nxt     = state;
      drain_ctr_nxt = drain_ctr;
      stall_cnt_nxt = stall_cnt;
      pc_we         = 1'b1;
      fd_we         = 1'b1;
      fd_flush      = 1'b0;
      dx_we         = 1'b1;
      dx_flush      = 1'b0;
      xm_we         = 1'b1;
      mw_we         = 1'b1;
      halted        = 1'b0;

      if (rst) begin
         pc_we    = 1'b0;
         fd_we    = 1'b0;
         dx_we    = 1'b0;
         xm_we    = 1'b0;
         mw_we    = 1'b0;
         fd_flush = 1'b1;
         dx_flush = 1'b1;
      end else if (mem_busy) begin
         pc_we  = 1'b0;
         fd_we  = 1'b0;
         dx_we  = 1'b0;
         xm_we  = 1'b0;
         mw_we  = 1'b0;
         halted = (state == S_HALTED);
      end else begin
         case (state)
            S_HALTED: begin
               pc_we  = 1'b0;
               fd_we  = 1'b0;
               dx_we  = 1'b0;
               xm_we  = 1'b0;
               mw_we  = 1'b0;
               halted = 1'b1;
            end
            S_DRAIN: begin
               // Older instructions keep retiring while the front end stays empty
               pc_we    = 1'b0;
               fd_flush = 1'b1;
               dx_flush = 1'b1;
               if (drain_ctr == '0) begin
                  state_nxt = S_HALTED;
               end else begin
                  drain_ctr_nxt = drain_ctr - CTR_W'(1);
               end
            end
            S_RUN: begin
               if (haz) begin
                  pc_we    = 1'b0;
                  fd_we    = 1'b0;
                  dx_flush = 1'b1;
                  if (stall_cnt != CNT_MAX) begin
                     stall_cnt_nxt = stall_cnt + 16'd1;
                  end
               end else begin
                  if ((br_fd | br_reg_fd) & br_taken) begin
                     fd_flush = 1'b1;
                  end
                  if (hlt_fd) begin
                     state_nxt     = S_DRAIN;
                     drain_ctr_nxt = DRAIN_LOAD;
                  end
               end
            end
            default: begin
               state_nxt = S_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Vector-table bench for pipeline_hazard_ctrl; expectations follow PIPE_CTRL_FWD_EN when defined.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] rs_fd, rt_fd, dst_dx, dst_xm;
   logic       use_rs_fd, use_rt_fd, br_fd, br_reg_fd, br_taken, hlt_fd;
   logic       wr_dx, mrd_dx, flag_wr_dx, wr_xm, mrd_xm, mem_busy;
   logic       pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, mw_we, halted;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_cnt = 16'd0;

   pipeline_hazard_ctrl #(.REG_AW(4), .DRAIN_CYC(3)) dut (
      .clk(clk), .rst(rst),
      .rs_fd(rs_fd), .rt_fd(rt_fd), .use_rs_fd(use_rs_fd), .use_rt_fd(use_rt_fd),
      .br_fd(br_fd), .br_reg_fd(br_reg_fd), .br_taken(br_taken), .hlt_fd(hlt_fd),
      .wr_dx(wr_dx), .dst_dx(dst_dx), .mrd_dx(mrd_dx), .flag_wr_dx(flag_wr_dx),
      .wr_xm(wr_xm), .dst_xm(dst_xm), .mrd_xm(mrd_xm), .mem_busy(mem_busy),
      .pc_we(pc_we), .fd_we(fd_we), .fd_flush(fd_flush), .dx_we(dx_we),
      .dx_flush(dx_flush), .xm_we(xm_we), .mw_we(mw_we), .halted(halted),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Output vector order: {pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, mw_we, halted}
   localparam logic [7:0] O_RST = 8'b0010_1000;
   localparam logic [7:0] O_RUN = 8'b1101_0110;
   localparam logic [7:0] O_BRT = 8'b1111_0110;
   localparam logic [7:0] O_HAZ = 8'b0001_1110;
   localparam logic [7:0] O_BSY = 8'b0000_0000;
   localparam logic [7:0] O_DRN = 8'b0111_1110;
   localparam logic [7:0] O_HLT = 8'b0000_0001;
   localparam logic [7:0] M_ALL = 8'b1111_1111;
   localparam logic [7:0] M_HAZ = 8'b1110_1111;
   localparam logic [7:0] M_DRN = 8'b1010_1111;
   localparam logic [7:0] M_HLT = 8'b1101_0111;
`ifdef PIPE_CTRL_FWD_EN
   localparam logic [7:0] O_FW = O_RUN;
   localparam logic [7:0] M_FW = M_ALL;
   localparam logic       I_FW = 1'b0;
`else
   localparam logic [7:0] O_FW = O_HAZ;
   localparam logic [7:0] M_FW = M_HAZ;
   localparam logic       I_FW = 1'b1;
`endif

   typedef struct {
      logic       rst;
      logic [3:0] rs, rt;
      logic       urs, urt, br, brr, tk, hlt, wdx;
      logic [3:0] ddx;
      logic       mdx, fdx, wxm;
      logic [3:0] dxm;
      logic       mxm, busy;
      logic [7:0] exp, mask;
      logic       inc, chkc;
   } vec_t;

   typedef struct {
      logic [7:0]  exp, mask;
      logic [15:0] cnt;
      logic        chkc;
      int          id;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];

   function automatic vec_t mk(input logic r, input logic [3:0] rs, input logic [3:0] rt,
                               input logic urs, input logic urt, input logic br, input logic brr,
                               input logic tk, input logic hlt, input logic wdx, input logic [3:0] ddx,
                               input logic mdx, input logic fdx, input logic wxm, input logic [3:0] dxm,
                               input logic mxm, input logic busy, input logic [7:0] exp,
                               input logic [7:0] mask, input logic inc, input logic chkc);
      vec_t v;
      v.rst = r; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.br = br; v.brr = brr;
      v.tk = tk; v.hlt = hlt; v.wdx = wdx; v.ddx = ddx; v.mdx = mdx; v.fdx = fdx;
      v.wxm = wxm; v.dxm = dxm; v.mxm = mxm; v.busy = busy;
      v.exp = exp; v.mask = mask; v.inc = inc; v.chkc = chkc;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst = v.rst; rs_fd = v.rs; rt_fd = v.rt; use_rs_fd = v.urs; use_rt_fd = v.urt;
      br_fd = v.br; br_reg_fd = v.brr; br_taken = v.tk; hlt_fd = v.hlt;
      wr_dx = v.wdx; dst_dx = v.ddx; mrd_dx = v.mdx; flag_wr_dx = v.fdx;
      wr_xm = v.wxm; dst_xm = v.dxm; mrd_xm = v.mxm; mem_busy = v.busy;
   endtask

   task automatic check_out();
      sb_t s;
      logic [7:0] got;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: no expected entry queued");
      end else begin
         s = sb_q.pop_front();
         got = {pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, mw_we, halted};
         if (((got ^ s.exp) & s.mask) != 8'd0) begin
            errors++;
            $display("FAIL ctrl step %0d: got %b required %b (mask %b)", s.id, got, s.exp, s.mask);
         end
         if (s.chkc) begin
            checks++;
            if (stall_cnt !== s.cnt) begin
               errors++;
               $display("FAIL stall_cnt step %0d: got %0d required %0d", s.id, stall_cnt, s.cnt);
            end
         end
      end
   endtask

   // Drive one vector after the edge, queue its expectation, compare on the falling edge
   task automatic step(input vec_t v, input int id);
      sb_t s;
      @(posedge clk);
      #1;
      drive(v);
      s.exp = v.exp; s.mask = v.mask; s.cnt = exp_cnt; s.chkc = v.chkc; s.id = id;
      sb_q.push_back(s);
      @(negedge clk);
      check_out();
      if (v.rst) exp_cnt = 16'd0;
      else if (v.inc && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
   endtask

   initial begin
      sb_t s;
      //              rst rs rt  urs urt br brr tk hlt wdx ddx mdx fdx wxm dxm mxm bsy exp    mask   inc  chk
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, M_ALL, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, M_ALL, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, M_ALL, 0, 1));
      // load-use on rs, then the load moves to MEM
      vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, O_HAZ, M_HAZ, 1, 1));
      vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, O_FW,  M_FW,  I_FW, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, M_ALL, 0, 1));
      // R0 immunity, unused source, load-use on rt
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, O_RUN, M_ALL, 0, 1));
      vecs.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, O_RUN, M_ALL, 0, 1));
      vecs.push_back(mk(0, 1, 7, 0, 1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, O_HAZ, M_HAZ, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_RUN, M_ALL, 0, 1));
      // B taken/not taken, flag hazard then flush
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BRT, M_ALL, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, M_ALL, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, O_HAZ, M_HAZ, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BRT, M_ALL, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, O_RUN, M_ALL, 0, 1));
      // BR behind LW: two stalls, then taken
      vecs.push_back(mk(0, 4, 0, 1, 0, 0, 1, 1, 0, 1, 4, 1, 0, 0, 0, 0, 0, O_HAZ, M_HAZ, 1, 1));
      vecs.push_back(mk(0, 4, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 4, 1, 0, O_HAZ, M_HAZ, 1, 1));
      vecs.push_back(mk(0, 4, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BRT, M_ALL, 0, 1));
      vecs.push_back(mk(0, 4, 0, 1, 0, 0, 1, 1, 0, 1, 4, 0, 0, 0, 0, 0, 0, O_HAZ, M_HAZ, 1, 1));
      vecs.push_back(mk(0, 4, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, O_FW,  M_FW,  I_FW, 1));
      // ALU RAW from MEM (rt) and EX (rs)
      vecs.push_back(mk(0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, O_FW,  M_FW,  I_FW, 1));
      vecs.push_back(mk(0, 6, 0, 1, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, O_FW,  M_FW,  I_FW, 1));
      // mem_busy over a load-use stall, then the stall completes
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 1, O_BSY, M_ALL, 0, 1));
      vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, O_HAZ, M_HAZ, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, M_ALL, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_BSY, M_ALL, 0, 1));
      // HLT waits under hazard, drains three cycles (one busy hold), then halts
      vecs.push_back(mk(0, 2, 0, 1, 0, 0, 0, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0, O_HAZ, M_HAZ, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, M_ALL, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN, M_DRN, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_BSY, M_ALL, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN, M_DRN, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN, M_DRN, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_HLT, M_HLT, 0, 1));
      vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, O_HLT, M_HLT, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_HLT, M_HLT, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, M_ALL, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, M_ALL, 0, 1));

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

      // Counter saturation: hold a load-use hazard long enough to pass 16'hFFFF
      @(posedge clk);
      #1;
      drive(vecs[3]);
      repeat (65540) @(posedge clk);
      s.exp = O_HAZ; s.mask = M_HAZ; s.cnt = 16'hFFFF; s.chkc = 1'b1; s.id = 1000;
      sb_q.push_back(s);
      @(negedge clk);
      check_out();
      exp_cnt = 16'hFFFF;

      step(vecs[0], 1001);
      step(vecs[2], 1002);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
